// File: rtl/vga_plot_sink.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// vga_plot_sink
//
// Receiving end of the pixel-plot interface used by the drawing engines.
// Every accepted plot is written into an internal WIDTH x HEIGHT x 3-bit
// framebuffer, which can be read back with a one-cycle latency. A built-in
// clear engine fills the framebuffer with CLEAR_COLOUR after reset and on
// request. Statistics counters record written, out-of-bounds and dropped
// plots.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   vga_x/y     plot coordinate (8-bit column, 7-bit row)
//   vga_colour  plot colour
//   vga_plot    plot strobe, one pixel per high cycle
//   clear       single-cycle request to clear the framebuffer
//   busy        high while the clear engine runs
//   rd_en       readback request (ignored while busy)
//   rd_x/rd_y   readback coordinate
//   rd_valid    readback data valid, one cycle after an accepted rd_en
//   rd_colour   readback data (0 for out-of-bounds coordinates)
//   plot_count  in-bounds pixels written since the last clear (saturating)
//   oob_count   out-of-bounds plots ignored (saturating)
//   drop_count  plots ignored because busy was high (saturating)
// ---------------------------------------------------------------------------
module vga_plot_sink #(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        clear,
    output logic        busy,
    input  logic        rd_en,
    input  logic [7:0]  rd_x,
    input  logic [6:0]  rd_y,
    output logic        rd_valid,
    output logic [2:0]  rd_colour,
    output logic [15:0] plot_count,
    output logic [7:0]  oob_count,
    output logic [7:0]  drop_count
);

    localparam int         NPIX      = WIDTH * HEIGHT;
    localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
    localparam logic [14:0] WIDTH15   = 15'(WIDTH);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [14:0] r_clr_addr;
    logic [14:0] w_clr_addr_next;

    // Framebuffer: one write port shared by clear engine and plots,
    // one registered read port.
    logic [2:0]  r_mem [NPIX];
    logic [2:0]  r_ram_q;

    logic        w_we;
    logic [14:0] w_waddr;
    logic [2:0]  w_wdata;

    logic        w_idle;
    logic        w_plot_inb;
    logic        w_rd_inb;
    logic [14:0] w_plot_addr;
    logic [14:0] w_rd_addr;
    logic        w_plot_accept;
    logic        w_plot_oob;
    logic        w_plot_drop;
    logic        w_rd_accept;

    logic        r_rd_valid;
    logic        r_rd_oob;
    logic [15:0] r_plot_count;
    logic [7:0]  r_oob_count;
    logic [7:0]  r_drop_count;

    // ------------------------------------------------------------------
    // Address decode. Out-of-bounds coordinates are forced to address 0 so
    // the RAM is never indexed past its end; their result is masked anyway.
    // ------------------------------------------------------------------
    assign w_idle      = (r_state == S_IDLE);
    assign w_plot_inb  = (32'(vga_x) < 32'(WIDTH)) && (32'(vga_y) < 32'(HEIGHT));
    assign w_rd_inb    = (32'(rd_x)  < 32'(WIDTH)) && (32'(rd_y)  < 32'(HEIGHT));
    assign w_plot_addr = w_plot_inb ? (15'(vga_y) * WIDTH15 + 15'(vga_x)) : 15'd0;
    assign w_rd_addr   = w_rd_inb   ? (15'(rd_y)  * WIDTH15 + 15'(rd_x))  : 15'd0;

    // Busy plots are dropped before bounds are considered.
    assign w_plot_accept = vga_plot &  w_idle &  w_plot_inb;
    assign w_plot_oob    = vga_plot &  w_idle & ~w_plot_inb;
    assign w_plot_drop   = vga_plot & ~w_idle;
    assign w_rd_accept   = rd_en & w_idle;

    // ------------------------------------------------------------------
    // Clear-engine FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= 15'd0;
        end else begin
            r_state    <= w_state_next;
            r_clr_addr <= w_clr_addr_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        w_we            = 1'b0;
        w_waddr         = w_plot_addr;
        w_wdata         = vga_colour;
        if (r_state == S_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
            w_wdata = CLEAR_COLOUR;
            if (clear) begin
                // A new request restarts the sweep from the beginning.
                w_clr_addr_next = 15'd0;
            end else if (r_clr_addr == LAST_ADDR) begin
                w_state_next    = S_IDLE;
                w_clr_addr_next = 15'd0;
            end else begin
                w_clr_addr_next = r_clr_addr + 15'd1;
            end
        end else begin
            // A plot coinciding with clear is still written; the sweep that
            // starts on the next edge overwrites it.
            w_we = w_plot_accept;
            if (clear) begin
                w_state_next    = S_CLEAR;
                w_clr_addr_next = 15'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Framebuffer RAM. Reading the old contents in the same block as the
    // write gives read-before-write behaviour on an address collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_ram_q <= r_mem[w_rd_addr];
    end

    // ------------------------------------------------------------------
    // Readback handshake and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid   <= 1'b0;
            r_rd_oob     <= 1'b0;
            r_plot_count <= 16'd0;
            r_oob_count  <= 8'd0;
            r_drop_count <= 8'd0;
        end else begin
            r_rd_valid <= w_rd_accept;
            r_rd_oob   <= ~w_rd_inb;

            // Clear has priority so a coincident plot still ends at zero.
            if (clear) begin
                r_plot_count <= 16'd0;
            end else if (w_plot_accept && (r_plot_count != 16'hFFFF)) begin
                r_plot_count <= r_plot_count + 16'd1;
            end

            if (w_plot_oob && (r_oob_count != 8'hFF)) begin
                r_oob_count <= r_oob_count + 8'd1;
            end

            if (w_plot_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    // The RAM output register carries no reset; the data is qualified here
    // so rd_colour is 0 whenever no valid in-bounds read is presented.
    assign rd_colour  = (r_rd_valid && !r_rd_oob) ? r_ram_q : 3'b000;
    assign rd_valid   = r_rd_valid;
    assign busy       = (r_state == S_CLEAR);
    assign plot_count = r_plot_count;
    assign oob_count  = r_oob_count;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_vga_plot_sink.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_vga_plot_sink
//
// Drives directed and random plot/read/clear traffic into vga_plot_sink.
// A reference model (2-D pixel array plus counters and a clear countdown)
// produces the expected readback data, which is queued with the cycle on
// which it is due; a separate monitor pops and compares on every rd_valid.
// ---------------------------------------------------------------------------
module tb_vga_plot_sink;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear;
    logic        busy;
    logic        rd_en;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic        rd_valid;
    logic [2:0]  rd_colour;
    logic [15:0] plot_count;
    logic [7:0]  oob_count;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    vga_plot_sink #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .CLEAR_COLOUR(3'b000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .clear      (clear),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_valid   (rd_valid),
        .rd_colour  (rd_colour),
        .plot_count (plot_count),
        .oob_count  (oob_count),
        .drop_count (drop_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [2:0] colour;
        int         due;
    } rd_exp_t;

    rd_exp_t sb[$];

    // Reference model
    logic [2:0] m_fb [W][H];
    int         m_left;   // clear writes still to come; >0 means busy
    int         m_plot;
    int         m_oob;
    int         m_drop;

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    function automatic void m_clear_fb();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                m_fb[x][y] = 3'b000;
    endfunction

    function automatic void m_reset();
        m_left = NPIX;
        m_plot = 0;
        m_oob  = 0;
        m_drop = 0;
        m_clear_fb();
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_counters();
        chk("busy",       int'(busy),       int'(m_left > 0));
        chk("plot_count", int'(plot_count), m_plot);
        chk("oob_count",  int'(oob_count),  m_oob);
        chk("drop_count", int'(drop_count), m_drop);
    endtask

    // One clock of stimulus; called and returns at a falling edge.
    task automatic step(input logic p, input int x, input int y, input logic [2:0] c,
                        input logic clr, input logic rd, input int rx, input int ry);
        vga_plot   = p;
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = c;
        clear      = clr;
        rd_en      = rd;
        rd_x       = 8'(rx);
        rd_y       = 7'(ry);
        @(posedge clk);
        cyc++;
        if (m_left > 0) begin
            if (p) m_drop = sat(m_drop + 1, 255);
            if (clr) begin
                m_left = NPIX;
                m_plot = 0;
            end else begin
                m_left--;
            end
        end else begin
            // Read first: a coincident plot is not yet visible.
            if (rd) sb.push_back('{colour: ((rx < W && ry < H) ? m_fb[rx][ry] : 3'b000), due: cyc});
            if (p) begin
                if (x < W && y < H) begin
                    m_fb[x][y] = c;
                    m_plot     = sat(m_plot + 1, 65535);
                end else begin
                    m_oob = sat(m_oob + 1, 255);
                end
            end
            if (clr) begin
                m_left = NPIX;
                m_plot = 0;
                m_clear_fb();
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 3'b000, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic rd(input int rx, input int ry);
        step(1'b0, 0, 0, 3'b000, 1'b0, 1'b1, rx, ry);
    endtask

    task automatic plot(input int x, input int y, input logic [2:0] c);
        step(1'b1, x, y, c, 1'b0, 1'b0, 0, 0);
    endtask

    // Counts the remaining busy cycles (bounded) and compares with expected.
    task automatic run_clear(input int expected);
        int n = 0;
        while (busy === 1'b1 && n < NPIX + 100) begin
            n++;
            idle();
        end
        chk("busy_cycles", n, expected);
    endtask

    // Readback monitor: decoupled from the stimulus.
    always @(negedge clk) begin
        rd_exp_t e;
        if (rd_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_spurious: got rd_valid=1 colour=%0d expected no read (cycle %0d)", rd_colour, cyc);
            end else begin
                e = sb.pop_front();
                if (rd_colour !== e.colour || cyc != e.due) begin
                    errors++;
                    $display("FAIL rd_data: got colour=%0d at cycle %0d expected colour=%0d at cycle %0d",
                             rd_colour, cyc, e.colour, e.due);
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            e = sb.pop_front();
            $display("FAIL rd_missing: got rd_valid=0 expected colour=%0d at cycle %0d", e.colour, e.due);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int x, y, rx, ry, sel;
        rst = 1'b1;
        vga_plot = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0;
        clear = 1'b0; rd_en = 1'b0; rd_x = '0; rd_y = '0;
        m_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",     int'(busy),       1);
        chk("rst_rd_valid", int'(rd_valid),   0);
        chk("rst_rd_colour",int'(rd_colour),  0);
        chk("rst_plot",     int'(plot_count), 0);
        chk("rst_oob",      int'(oob_count),  0);
        chk("rst_drop",     int'(drop_count), 0);

        // Power-up clear, then corners read back as clear colour
        rst = 1'b0;
        run_clear(NPIX);
        check_counters();
        rd(0, 0);
        rd(W - 1, H - 1);
        idle(); idle();

        // Single plot and neighbour
        plot(80, 60, 3'b101);
        rd(80, 60);
        idle();
        check_counters();
        rd(81, 60);
        idle();

        // Out-of-bounds plots
        plot(160, 0, 3'b111);
        plot(0, 120, 3'b111);
        rd(0, 0);
        idle();
        check_counters();

        // Clear with coincident plot, then a dropped plot during busy
        step(1'b1, 20, 20, 3'b111, 1'b1, 1'b0, 0, 0);
        plot(10, 10, 3'b010);
        check_counters();
        run_clear(NPIX - 1);
        check_counters();
        rd(80, 60);
        rd(20, 20);
        rd(10, 10);
        idle();

        // Same-cycle plot and read of one address
        step(1'b1, 5, 5, 3'b011, 1'b0, 1'b1, 5, 5);
        rd(5, 5);
        idle(); idle();
        check_counters();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 7));
            if (sel < 6) begin
                x = int'($urandom_range(0, 15));  y = int'($urandom_range(0, 7));
            end else if (sel == 6) begin
                x = int'($urandom_range(0, 199)); y = int'($urandom_range(0, 127));
            end else begin
                x = int'($urandom_range(0, W - 1)); y = int'($urandom_range(0, H - 1));
            end
            if ($urandom_range(0, 5) == 0) begin
                rx = int'($urandom_range(0, 255)); ry = int'($urandom_range(0, 127));
            end else begin
                rx = int'($urandom_range(0, 15)); ry = int'($urandom_range(0, 7));
            end
            step(1'($urandom_range(0, 1)), x, y, 3'($urandom), 1'b0,
                 1'($urandom_range(0, 1)), rx, ry);
            if (i % 100 == 99) check_counters();
        end
        idle(); idle();
        chk("sb_drained", sb.size(), 0);

        // Reset 100 cycles into a clear
        step(1'b0, 0, 0, 3'b000, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 99; i++)
            step(1'(i % 3 == 0), 1, 1, 3'b001, 1'b0, 1'b0, 0, 0);
        check_counters();
        rst = 1'b1;
        m_reset();
        #2;
        chk("midclr_busy",  int'(busy),       1);
        chk("midclr_valid", int'(rd_valid),   0);
        chk("midclr_oob",   int'(oob_count),  0);
        chk("midclr_drop",  int'(drop_count), 0);
        chk("midclr_plot",  int'(plot_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_clear(NPIX);
        check_counters();
        rd(5, 5);
        idle(); idle();
        chk("sb_final", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_plot_sink.md
# vga_plot_sink

Receiving end of the pixel-plot interface driven by the drawing engines (circle, Reuleaux triangle, fill). It samples `vga_x`/`vga_y`/`vga_colour`/`vga_plot` every clock and writes each accepted pixel into an internal 160×120×3-bit framebuffer. It provides a one-cycle-latency readback port and statistics counters, so benches and on-chip checkers can inspect exactly what a drawer produced. A built-in clear engine initialises the framebuffer after reset and on request.

## Interface
- `WIDTH`, default 160: framebuffer columns.
- `HEIGHT`, default 120: framebuffer rows.
- `CLEAR_COLOUR`, default 3'b000: value written by the clear engine.

Ports:
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `vga_x`  in  8  plot column.
- `vga_y`  in  7  plot row.
- `vga_colour`  in  3  plot colour.
- `vga_plot`  in  1  plot strobe, one pixel per high cycle.
- `clear`  in  1  single-cycle request to clear the framebuffer.
- `busy`  out  1  high while the clear engine runs.
- `rd_en`  in  1  readback request.
- `rd_x`  in  8  readback column.
- `rd_y`  in  7  readback row.
- `rd_valid`  out  1  readback data valid.
- `rd_colour`  out  3  readback data.
- `plot_count`  out  16  in-bounds pixels written since the last clear; saturates at 65535.
- `oob_count`  out  8  out-of-bounds plots ignored; saturates at 255.
- `drop_count`  out  8  plots ignored because `busy` was high; saturates at 255.

## Operation
- States:
  - CLEAR: an address counter `clr_addr` (15 bits) steps 0 … WIDTH*HEIGHT−1, writing `CLEAR_COLOUR` at one address per cycle.
  - IDLE: the normal operating state.
- State transitions:
  - Reset enters CLEAR with `clr_addr`=0.
  - CLEAR → IDLE after the write at address WIDTH*HEIGHT−1.
  - IDLE → CLEAR when `clear` is sampled high.
  - `clear` sampled high while already in CLEAR restarts `clr_addr` at 0.
- `busy` = (state == CLEAR).
- Pixel address = `vga_y`*WIDTH + `vga_x`, computed at 15 bits with no truncation.
- Plot accepted when `vga_plot`=1, IDLE, `vga_x` < WIDTH and `vga_y` < HEIGHT. An accepted plot writes the colour and increments `plot_count`.
- Plot with `vga_plot`=1 while in IDLE but out of bounds: no write; `oob_count` increments.
- Plot with `vga_plot`=1 while `busy` is high: no write; `drop_count` increments. Out-of-bounds is not evaluated for these plots.
- Entering CLEAR, whether on reset or on `clear`, zeroes `plot_count`. `oob_count` and `drop_count` are zeroed only by `rst`.
- Readback request with `rd_en`=1 in IDLE:
  - In-bounds coordinate: the next cycle gives `rd_valid`=1 and `rd_colour` = the stored value.
  - Out-of-bounds coordinate: the next cycle gives `rd_valid`=1 and `rd_colour`=3'b000.
- `rd_en` while `busy` is high is ignored; `rd_valid` stays 0.
- Same-cycle plot and read of the same address: the read returns the pre-write value (read-before-write).
- Framebuffer is a single-write, single-read synchronous RAM. The write port is shared between the clear engine and plots; plots are never accepted during CLEAR, so there is no write conflict.

## Timing
- Reset values: `busy`=1, `rd_valid`=0, `rd_colour`=0, all counters 0, state CLEAR, `clr_addr`=0.
- After `rst` falls, the first clear write occurs on the first rising edge. `busy` falls WIDTH*HEIGHT (19200) cycles after the first edge. The first plot can be accepted in the cycle `busy` is low.
- `clear` sampled at edge N: `busy` is high after edge N, the clear writes occupy edges N+1 … N+19200, and `busy` is low after edge N+19200.
- A plot sampled at edge N is visible to a read sampled at edge N+1 or later.
- Readback latency is exactly 1 cycle. `rd_valid` is a registered copy of the accepted `rd_en`. Back-to-back reads give back-to-back valid data.
- Counters update on the edge that samples the plot; the new value is visible in the following cycle.
- `rst` asserted mid-clear or mid-readback aborts it immediately: outputs return to reset values and the clear restarts from 0. Framebuffer contents are undefined until that clear completes.
- `clear` and `vga_plot` in the same IDLE cycle: the plot is accepted and written, then the clear begins and overwrites it. `plot_count` ends at 0.

## Test plan
- Reset release, idle inputs → `busy` high for exactly 19200 cycles, then low; reading (0,0) and (159,119) returns 3'b000 with `rd_valid` one cycle after `rd_en`.
- Plot (80,60,3'b101) in IDLE, then read (80,60) → `rd_colour`=3'b101; `plot_count`=1; reading (81,60) → 3'b000.
- Plot (160,0,3'b111) and then (0,120,3'b111) → `oob_count`=2, `plot_count` unchanged; reading (0,0) → 3'b000.
- Pulse `clear`, then plot (10,10,3'b010) on the next cycle → `drop_count`=1. After `busy` falls, reading (80,60) → 3'b000 and `plot_count`=0.
- Same cycle: plot (5,5,3'b011) and read (5,5) → `rd_colour`=3'b000. A read on the next cycle → 3'b011.
- Assert `rst` 100 cycles into a clear → `busy` stays high; the full 19200-cycle clear reruns after release and `oob_count`/`drop_count` read 0.
